// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and memory-wait hold,
// plus saturating stall/flush performance counters.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// RUN      | normal issue; branch flush or load-use stall may be raised
// LU_STALL | bubble already inserted for a load; load-use check is ignored
// MEM_WAIT | data memory was busy last cycle; behaves as RUN once it frees up
module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_reg_address_rs,
    input  logic [4:0]  ID_reg_address_rt,
    input  logic        ID_uses_rt,
    input  logic        EXE_mem_read,
    input  logic [4:0]  EXE_reg_address_rt,
    input  logic        EXE_branch_taken,
    input  logic        mem_busy,
    input  logic        clear_counters,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EXE_flush,
    output logic        pipe_hold,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t      state_q, state_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_events_q, flush_events_d;

    logic        lu;
    logic        rs_match;
    logic        rt_match;
    logic        lu_armed;

    // Register zero is hard-wired, so a load targeting it never creates a dependency.
    always_comb begin
        rs_match = (EXE_reg_address_rt == ID_reg_address_rs);
        rt_match = ID_uses_rt && (EXE_reg_address_rt == ID_reg_address_rt);
        lu       = EXE_mem_read && (EXE_reg_address_rt != 5'd0) && (rs_match || rt_match);
    end

    // Encoding 3 falls into the default arm and is treated exactly like RUN.
    always_comb begin
        case (state_q)
            ST_LU_STALL: lu_armed = 1'b0;
            default:     lu_armed = 1'b1;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EXE_flush = 1'b0;
        pipe_hold    = 1'b0;
        state_d      = ST_RUN;

        if (mem_busy) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
            state_d     = ST_MEM_WAIT;
        end else if (EXE_branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EXE_flush = 1'b1;
            state_d      = ST_RUN;
        end else if (lu && lu_armed) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EXE_flush = 1'b1;
            state_d      = ST_LU_STALL;
        end
    end

    // A clear wins over any increment on the same edge.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;

        if (clear_counters) begin
            stall_cycles_d = 16'd0;
            flush_events_d = 16'd0;
        end else begin
            if (!pc_write && (stall_cycles_q != CNT_MAX)) begin
                stall_cycles_d = stall_cycles_q + 16'd1;
            end
            if (IF_ID_flush && (flush_events_q != CNT_MAX)) begin
                flush_events_d = flush_events_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            stall_cycles_q <= 16'd0;
            flush_events_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_hazard_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_reg_address_rs;
    logic [4:0]  ID_reg_address_rt;
    logic        ID_uses_rt;
    logic        EXE_mem_read;
    logic [4:0]  EXE_reg_address_rt;
    logic        EXE_branch_taken;
    logic        mem_busy;
    logic        clear_counters;
    logic        pc_write;
    logic        IF_ID_write;
    logic        IF_ID_flush;
    logic        ID_EXE_flush;
    logic        pipe_hold;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;

    int tests_run = 0;
    int tests_failed = 0;

    hazard_unit dut (
        .clk                (clk),
        .rst                (rst),
        .ID_reg_address_rs  (ID_reg_address_rs),
        .ID_reg_address_rt  (ID_reg_address_rt),
        .ID_uses_rt         (ID_uses_rt),
        .EXE_mem_read       (EXE_mem_read),
        .EXE_reg_address_rt (EXE_reg_address_rt),
        .EXE_branch_taken   (EXE_branch_taken),
        .mem_busy           (mem_busy),
        .clear_counters     (clear_counters),
        .pc_write           (pc_write),
        .IF_ID_write        (IF_ID_write),
        .IF_ID_flush        (IF_ID_flush),
        .ID_EXE_flush       (ID_EXE_flush),
        .pipe_hold          (pipe_hold),
        .state              (state),
        .stall_cycles       (stall_cycles),
        .flush_events       (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the pipeline is "doing" (0 normal, 1 just bubbled a load,
    // 2 waiting on memory) and plain integer counters clipped at 65535.
    int   m_mode;
    int   m_stall;
    int   m_flush;
    int   e_next;
    logic e_pc, e_ifw, e_iff, e_idf, e_hold;

    function automatic logic [4:0] dut_ctrl();
        return {pc_write, IF_ID_write, IF_ID_flush, ID_EXE_flush, pipe_hold};
    endfunction

    task automatic eval_model();
        bit dep;
        dep = EXE_mem_read && EXE_reg_address_rt != 0 &&
              (EXE_reg_address_rt == ID_reg_address_rs ||
               (ID_uses_rt && EXE_reg_address_rt == ID_reg_address_rt));
        {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b11000;
        e_next = 0;
        if (mem_busy) begin
            {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b00001;
            e_next = 2;
        end else if (EXE_branch_taken) begin
            {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b11110;
        end else if (dep && m_mode != 1) begin
            {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b00010;
            e_next = 1;
        end
    endtask

    // Advance one clock: model updates at the rising edge, control returns at the falling edge.
    task automatic step();
        eval_model();
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (clear_counters) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e_pc) m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
                if (e_iff) m_flush = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
            end
            m_mode = e_next;
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic mrd, input logic [4:0] ert, input logic br,
                          input logic busy, input logic clr);
        ID_reg_address_rs  = rs;
        ID_reg_address_rt  = rt;
        ID_uses_rt         = urt;
        EXE_mem_read       = mrd;
        EXE_reg_address_rt = ert;
        EXE_branch_taken   = br;
        mem_busy           = busy;
        clear_counters     = clr;
        #1;
        eval_model();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({state, stall_cycles, flush_events} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: got state=%0d stall=%0d flush=%0d, want 0/0/0",
                     state, stall_cycles, flush_events);
        end
        tests_run++;
        if (dut_ctrl() !== 5'b11110) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 11110", dut_ctrl());
        end
        step();
        tests_run++;
        if (flush_events !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_hold_counters: got flush=%0d want 0", flush_events);
        end
        rst = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_load_use();
        set_in(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (dut_ctrl() !== 5'b00010) begin
            tests_failed++;
            $display("FAIL lu_stall_cycle: got %b want 00010", dut_ctrl());
        end
        step();
        tests_run++;
        if ({state, dut_ctrl(), stall_cycles} !== {2'd1, 5'b11000, 16'd1}) begin
            tests_failed++;
            $display("FAIL lu_after: got state=%0d ctrl=%b stall=%0d want 1/11000/1",
                     state, dut_ctrl(), stall_cycles);
        end
        step();
        set_in(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (dut_ctrl() !== 5'b00010) begin
            tests_failed++;
            $display("FAIL lu_rt_match: got %b want 00010", dut_ctrl());
        end
        step();
        step();
    endtask

    task automatic test_reg_zero();
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (dut_ctrl() !== 5'b11000) begin
            tests_failed++;
            $display("FAIL reg_zero: got %b want 11000", dut_ctrl());
        end
        set_in(5'd1, 5'd6, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (dut_ctrl() !== 5'b11000) begin
            tests_failed++;
            $display("FAIL rt_unused: got %b want 11000", dut_ctrl());
        end
        step();
        tests_run++;
        if (state !== 2'd0) begin
            tests_failed++;
            $display("FAIL no_stall_state: got %0d want 0", state);
        end
    endtask

    task automatic test_branch_lu();
        int s0, f0;
        s0 = m_stall; f0 = m_flush;
        set_in(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (dut_ctrl() !== 5'b11110) begin
            tests_failed++;
            $display("FAIL branch_lu: got %b want 11110", dut_ctrl());
        end
        step();
        tests_run++;
        if ({state, stall_cycles, flush_events} !== {2'd0, 16'(s0), 16'(f0 + 1)}) begin
            tests_failed++;
            $display("FAIL branch_lu_counters: got state=%0d stall=%0d flush=%0d want 0/%0d/%0d",
                     state, stall_cycles, flush_events, s0, f0 + 1);
        end
    endtask

    task automatic test_mem_busy_branch();
        for (int i = 0; i < 3; i++) begin
            set_in(5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
            tests_run++;
            if (dut_ctrl() !== 5'b00001) begin
                tests_failed++;
                $display("FAIL busy_hold[%0d]: got %b want 00001", i, dut_ctrl());
            end
            step();
        end
        set_in(5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({state, dut_ctrl()} !== {2'd2, 5'b11110}) begin
            tests_failed++;
            $display("FAIL busy_release_flush: got state=%0d ctrl=%b want 2/11110",
                     state, dut_ctrl());
        end
        step();
        tests_run++;
        if ({state, stall_cycles, flush_events} !== {2'd0, 16'(m_stall), 16'(m_flush)}) begin
            tests_failed++;
            $display("FAIL busy_counters: got %0d/%0d/%0d want 0/%0d/%0d",
                     state, stall_cycles, flush_events, m_stall, m_flush);
        end
    endtask

    task automatic test_saturation();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        m_stall = 65534;
        m_mode  = 2;
        tests_run++;
        if (stall_cycles !== 16'd65534) begin
            tests_failed++;
            $display("FAIL sat_preload: got %0d want 65534", stall_cycles);
        end
        repeat (3) step();
        tests_run++;
        if (stall_cycles !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_top: got %h want ffff", stall_cycles);
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step();
        tests_run++;
        if ({stall_cycles, flush_events} !== 32'd0) begin
            tests_failed++;
            $display("FAIL clear_over_stall: got stall=%0d flush=%0d want 0/0",
                     stall_cycles, flush_events);
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_async_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        tests_run++;
        if (state !== 2'd2 || stall_cycles !== 16'd2) begin
            tests_failed++;
            $display("FAIL pre_reset_memwait: got state=%0d stall=%0d want 2/2", state, stall_cycles);
        end
        mem_busy = 1'b0;
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({state, stall_cycles, flush_events} !== 34'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got state=%0d stall=%0d flush=%0d want 0/0/0",
                     state, stall_cycles, flush_events);
        end
        m_mode = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        rst = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (dut_ctrl() !== 5'b11000) begin
            tests_failed++;
            $display("FAIL post_reset_run: got %b want 11000", dut_ctrl());
        end
        step();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 30) == 0));
            tests_run++;
            if ({state, dut_ctrl(), stall_cycles, flush_events} !==
                {2'(m_mode), e_pc, e_ifw, e_iff, e_idf, e_hold, 16'(m_stall), 16'(m_flush)}) begin
                tests_failed++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got st=%0d ctrl=%b stall=%0d flush=%0d want %0d/%b/%0d/%0d",
                             i, state, dut_ctrl(), stall_cycles, flush_events, m_mode,
                             {e_pc, e_ifw, e_iff, e_idf, e_hold}, m_stall, m_flush);
            end
            step();
        end
    endtask

    initial begin
        m_mode = 0; m_stall = 0; m_flush = 0;
        test_reset();
        test_load_use();
        test_reg_zero();
        test_branch_lu();
        test_mem_busy_branch();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
